// File: rtl/u2b_pkg.sv
// u2b_pkg: shared types and width helpers for the windowed unary-to-binary
// converter (u2b_window_cnt and its u2b_ones_cnt counter).
package u2b_pkg;

  // Converter control states.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } u2b_state_e;

  // Result width: count needs LOGLEN+1 bits (0..N), plus one for the sign
  // of the bipolar mapping.
  function automatic int u2b_res_w(input int loglen);
    return loglen + 2;
  endfunction

  // Bipolar offset: the window length N = 2^LOGLEN.
  function automatic int u2b_offset(input int loglen);
    return 1 << loglen;
  endfunction

endpackage

// File: rtl/u2b_ones_cnt.sv
// u2b_ones_cnt: window bit counter and ones counter. Both are LOGLEN+1 bits
// so an all-ones window of N bits reaches exactly N without wrapping.
// tc flags the enabled bit that completes the window (bit_cnt reaches N).
module u2b_ones_cnt
  import u2b_pkg::*;
#(
  parameter int LOGLEN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              bit_in,
  output logic [LOGLEN:0]   ones_cnt,
  output logic              tc
);

  localparam int CW = LOGLEN + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << LOGLEN) - 1);

  logic [CW-1:0] bit_cnt;

  // Terminal count: this enabled bit is the N-th of the window.
  assign tc = en && (bit_cnt == LAST);

  // Clear wins over counting; stalled cycles (en=0) hold both counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      ones_cnt <= '0;
    end else if (clr) begin
      bit_cnt  <= '0;
      ones_cnt <= '0;
    end else if (en) begin
      bit_cnt  <= bit_cnt + CW'(1);
      ones_cnt <= ones_cnt + CW'(bit_in);
    end
  end

endmodule

// File: rtl/u2b_window_cnt.sv
// u2b_window_cnt: counts the ones in an N = 2^LOGLEN bit unipolar stream
// with a start/done handshake. Build option U2B_BIPOLAR_EN maps the count to
// the two's-complement bipolar value 2*ones - N; otherwise result is the
// plain count.
//
// Timeline with no stalls, start sampled at edge t:
//   t       : RUN, counters cleared
//   t+1..t+N: one bit accepted per edge; edge t+N returns to IDLE
//   t+N+1   : done pulses, result loaded; a start sampled here opens the
//             next window, so back-to-back throughput is N+1 cycles.
module u2b_window_cnt
  import u2b_pkg::*;
#(
  parameter int LOGLEN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_en,
  input  logic              in,
  output logic              busy,
  output logic              done,
  output logic [LOGLEN+1:0] result
);

  localparam int RES_W = u2b_res_w(LOGLEN);

  u2b_state_e        state_q, state_d;
  logic              clr;
  logic              cnt_en;
  logic              tc;
  logic              fin_q;
  logic [LOGLEN:0]   ones_cnt;
  logic [RES_W-1:0]  res_map;

  u2b_ones_cnt #(.LOGLEN(LOGLEN)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .en       (cnt_en),
    .bit_in   (in),
    .ones_cnt (ones_cnt),
    .tc       (tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: start only opens a window from IDLE; a window always runs
  // to completion. Inputs are ignored in IDLE.
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          clr     = 1'b1;
        end
      end
      RUN: begin
        cnt_en = in_en;
        if (tc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);

  // Map the final count onto the result encoding.
`ifdef U2B_BIPOLAR_EN
  localparam logic [RES_W-1:0] OFS = RES_W'(u2b_offset(LOGLEN));
  always_comb begin
    res_map = {ones_cnt, 1'b0} - OFS;
  end
`else
  always_comb begin
    res_map = {1'b0, ones_cnt};
  end
`endif

  // One edge after the last bit lands: pulse done and capture the result,
  // which then holds until the next window completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fin_q  <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      fin_q <= tc;
      done  <= fin_q;
      if (fin_q) result <= res_map;
    end
  end

endmodule
